lcd_ghost_blend: RTL and testbench

- Downstream of the LCD video timing stage.
- Consumes its pixel-rate RGB/sync/blank stream and emulates DMG/GBC LCD persistence by blending each visible pixel with the same pixel from the previous frame.
- Keeps a full-frame previous-pixel store and delivers a delay-matched RGB/sync stream to the scaler/video output.

---
 rtl/lcd_ghost_blend.sv | 141 ++++++++++++++
 tb/tb_lcd_ghost_blend.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ghost_blend.sv
// LCD persistence emulation: blends each visible pixel with the same pixel of the
// previous frame, held in a full-frame store, behind a two-stage pixel pipeline.
module lcd_ghost_blend #(
  parameter int unsigned H  = 160,
  parameter int unsigned V  = 144,
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 15
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ce_pix,
  input  logic [1:0]    blend_mode,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          blank_in,
  input  logic [DW-1:0] r_in,
  input  logic [DW-1:0] g_in,
  input  logic [DW-1:0] b_in,
  output logic          ce_pix_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          blank_out,
  output logic [DW-1:0] r_out,
  output logic [DW-1:0] g_out,
  output logic [DW-1:0] b_out,
  output logic          frame_valid
);

  localparam int unsigned NPIX = H * V;
  localparam int unsigned PW   = 3 * DW;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(NPIX);
  localparam logic [AW:0]   OVER_CNT  = (AW+1)'(NPIX + 1);

  logic [PW-1:0] mem [NPIX];

  logic          vs_prev_q;
  logic [AW-1:0] ptr_q, ptr_d, ptr_base;
  logic [AW:0]   cnt_q, cnt_d, cnt_base;
  logic [1:0]    mode_q, mode_d;
  logic          fv_q, fv_d;
  logic          frame_start, we_d;

  logic          s1_hs_q, s1_vs_q, s1_blank_q, s1_we_q;
  logic [PW-1:0] s1_pix_q, rd_q;
  logic [AW-1:0] s1_addr_q;
  logic [DW-1:0] r_bl, g_bl, b_bl;

  function automatic logic [DW-1:0] blend_ch(input logic [DW-1:0] c, input logic [DW-1:0] p,
                                             input logic [1:0] m, input logic fv);
    logic [DW:0]   half;
    logic [DW+1:0] quarter;
    half    = {1'b0, c} + {1'b0, p} + (DW+1)'(1);
    quarter = {2'b00, c} + {1'b0, c, 1'b0} + {2'b00, p} + (DW+2)'(2);
    if (!fv || m == 2'd0) return c;
    else if (m == 2'd2)   return quarter[DW+1:2];
    else                  return half[DW:1];
  endfunction

  // Frame start restarts addressing for this very pixel, so a visible pixel on the vs edge maps to address 0.
  always_comb begin
    frame_start = vs_in && !vs_prev_q;
    ptr_base    = frame_start ? '0 : ptr_q;
    cnt_base    = frame_start ? '0 : cnt_q;
    ptr_d       = ptr_base;
    cnt_d       = cnt_base;
    mode_d      = mode_q;
    fv_d        = fv_q;
    we_d        = 1'b0;
    if (frame_start) begin
      mode_d = blend_mode;
      fv_d   = (cnt_q == FULL_CNT) && (mode_q != 2'd0) && (blend_mode != 2'd0);
    end
    if (!blank_in) begin
      we_d  = (cnt_base < FULL_CNT);
      ptr_d = (ptr_base == LAST_ADDR) ? ptr_base : ptr_base + AW'(1);
      cnt_d = (cnt_base == OVER_CNT) ? cnt_base : cnt_base + (AW+1)'(1);
    end
  end

  always_comb begin
    r_bl = blend_ch(s1_pix_q[3*DW-1:2*DW], rd_q[3*DW-1:2*DW], mode_q, fv_q);
    g_bl = blend_ch(s1_pix_q[2*DW-1:DW],   rd_q[2*DW-1:DW],   mode_q, fv_q);
    b_bl = blend_ch(s1_pix_q[DW-1:0],      rd_q[DW-1:0],      mode_q, fv_q);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      ce_pix_out  <= 1'b0;
      vs_prev_q   <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= 2'd0;
      fv_q        <= 1'b0;
      s1_hs_q     <= 1'b0;
      s1_vs_q     <= 1'b0;
      s1_blank_q  <= 1'b1;
      s1_we_q     <= 1'b0;
      s1_pix_q    <= '0;
      s1_addr_q   <= '0;
      hs_out      <= 1'b0;
      vs_out      <= 1'b0;
      blank_out   <= 1'b1;
      r_out       <= '0;
      g_out       <= '0;
      b_out       <= '0;
      frame_valid <= 1'b0;
    end else begin
      ce_pix_out <= ce_pix;
      if (ce_pix) begin
        vs_prev_q   <= vs_in;
        ptr_q       <= ptr_d;
        cnt_q       <= cnt_d;
        mode_q      <= mode_d;
        fv_q        <= fv_d;
        frame_valid <= fv_d;
        s1_hs_q     <= hs_in;
        s1_vs_q     <= vs_in;
        s1_blank_q  <= blank_in;
        s1_we_q     <= we_d;
        s1_pix_q    <= {r_in, g_in, b_in};
        s1_addr_q   <= ptr_base;
        hs_out      <= s1_hs_q;
        vs_out      <= s1_vs_q;
        blank_out   <= s1_blank_q;
        r_out       <= s1_blank_q ? '0 : r_bl;
        g_out       <= s1_blank_q ? '0 : g_bl;
        b_out       <= s1_blank_q ? '0 : b_bl;
      end
    end
  end

  // Store holds raw input pixels; a read colliding with a write returns the old word.
  always_ff @(posedge clk_sys) begin
    if (ce_pix) begin
      rd_q <= mem[ptr_base];
      if (s1_we_q && reset_n) mem[s1_addr_q] <= s1_pix_q;
    end
  end

endmodule

// File: tb/tb_lcd_ghost_blend.sv
// Bench for lcd_ghost_blend on a reduced 16x8 raster: directed frame sequences plus
// random sync/blank traffic, compared against a frame-level reference model.
module tb_lcd_ghost_blend;

  localparam int unsigned H  = 16;
  localparam int unsigned V  = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 7;
  localparam int unsigned HV = H * V;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          ce_pix = 1'b0;
  logic [1:0]    blend_mode = 2'd0;
  logic          hs_in = 1'b0, vs_in = 1'b0, blank_in = 1'b1;
  logic [DW-1:0] r_in = '0, g_in = '0, b_in = '0;
  logic          ce_pix_out, hs_out, vs_out, blank_out, frame_valid;
  logic [DW-1:0] r_out, g_out, b_out;

  lcd_ghost_blend #(.H(H), .V(V), .DW(DW), .AW(AW)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix), .blend_mode(blend_mode),
    .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .ce_pix_out(ce_pix_out), .hs_out(hs_out), .vs_out(vs_out), .blank_out(blank_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .frame_valid(frame_valid)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        hs;
    logic        vs;
    logic        bl;
    logic [23:0] rgb;
    int          idx;
  } exp_t;

  exp_t        q[$];
  logic [23:0] store [HV];
  logic [23:0] last_out [HV];
  int unsigned m_cnt;
  logic [1:0]  m_mode;
  logic        m_fv, m_vsp;
  int          checks = 0;
  int          errors = 0;
  int          gap = 1;

  function automatic logic [7:0] bl8(input logic [7:0] c, input logic [7:0] p,
                                     input logic [1:0] m, input logic fv);
    int ci, pv;
    if (!fv || m == 2'd0) return c;
    ci = int'(c);
    pv = int'(p);
    if (m == 2'd2) return 8'((3 * ci + pv + 2) / 4);
    return 8'((ci + pv + 1) / 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    exp_t e;
    q.delete();
    e.hs = 1'b0; e.vs = 1'b0; e.bl = 1'b1; e.rgb = 24'h0; e.idx = -1;
    q.push_back(e);
    m_cnt = 0; m_mode = 2'd0; m_fv = 1'b0; m_vsp = 1'b0;
  endtask

  task automatic do_reset();
    ce_pix  = 1'b0;
    reset_n = 1'b0;
    @(posedge clk_sys); #1;
    chk("rst r_out",       32'(r_out), 32'h0);
    chk("rst g_out",       32'(g_out), 32'h0);
    chk("rst b_out",       32'(b_out), 32'h0);
    chk("rst blank_out",   32'(blank_out), 32'h1);
    chk("rst hs_out",      32'(hs_out), 32'h0);
    chk("rst vs_out",      32'(vs_out), 32'h0);
    chk("rst ce_pix_out",  32'(ce_pix_out), 32'h0);
    chk("rst frame_valid", 32'(frame_valid), 32'h0);
    reset_n = 1'b1;
    model_reset();
  endtask

  // One ce_pix pulse: model the pixel, then check the outputs that emerge on that edge.
  task automatic pix(input logic hs, input logic vs, input logic bl, input logic [23:0] c, input int idx);
    exp_t e;
    int unsigned a;
    hs_in = hs; vs_in = vs; blank_in = bl;
    {r_in, g_in, b_in} = c;
    ce_pix = 1'b1;
    if (vs && !m_vsp) begin
      m_fv   = (m_cnt == HV) && (m_mode != 2'd0) && (blend_mode != 2'd0);
      m_mode = blend_mode;
      m_cnt  = 0;
    end
    m_vsp = vs;
    e.hs = hs; e.vs = vs; e.bl = bl; e.idx = bl ? -1 : idx;
    if (bl) e.rgb = 24'h0;
    else begin
      a = (m_cnt < HV) ? m_cnt : HV - 1;
      e.rgb = {bl8(c[23:16], store[a][23:16], m_mode, m_fv),
               bl8(c[15:8],  store[a][15:8],  m_mode, m_fv),
               bl8(c[7:0],   store[a][7:0],   m_mode, m_fv)};
      if (m_cnt < HV) store[a] = c;
      if (m_cnt < HV + 1) m_cnt++;
    end
    q.push_back(e);
    @(posedge clk_sys); #1;
    chk("ce_pix_out", 32'(ce_pix_out), 32'h1);
    e = q.pop_front();
    chk("hs_out",      32'(hs_out), 32'(e.hs));
    chk("vs_out",      32'(vs_out), 32'(e.vs));
    chk("blank_out",   32'(blank_out), 32'(e.bl));
    chk("rgb_out",     32'({r_out, g_out, b_out}), 32'(e.rgb));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    if (e.idx >= 0) last_out[e.idx] = {r_out, g_out, b_out};
    ce_pix = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk_sys); #1;
      chk("ce_pix_out idle", 32'(ce_pix_out), 32'h0);
    end
  endtask

  // Frame: 2 vsync blank pixels, then lines of H visible pixels plus a 3-pixel hblank.
  task automatic frame(input int lines, input logic [23:0] c0, input logic [23:0] c1,
                       input int sw_line, input logic [1:0] sw_mode);
    pix(1'b0, 1'b1, 1'b1, 24'h0, -1);
    pix(1'b0, 1'b1, 1'b1, 24'h0, -1);
    for (int l = 0; l < lines; l++) begin
      if (l == sw_line) blend_mode = sw_mode;
      for (int x = 0; x < int'(H); x++)
        pix(1'b0, 1'b0, 1'b0, ((x % 2) == 1) ? c1 : c0, l * int'(H) + x);
      pix(1'b0, 1'b0, 1'b1, 24'h0, -1);
      pix(1'b1, 1'b0, 1'b1, 24'h0, -1);
      pix(1'b0, 1'b0, 1'b1, 24'h0, -1);
    end
  endtask

  initial begin
    do_reset();

    // Constant frames, mode 1: pass-through first, then valid blending of equal data
    blend_mode = 2'd1;
    frame(V, 24'h4080C0, 24'h4080C0, -1, 2'd0);
    chk("f1 frame_valid", 32'(frame_valid), 32'h0);
    chk("f1 pix0", 32'(last_out[0]), 32'h4080C0);
    frame(V, 24'h4080C0, 24'h4080C0, -1, 2'd0);
    chk("f2 frame_valid", 32'(frame_valid), 32'h1);
    chk("f2 pix0", 32'(last_out[0]), 32'h4080C0);
    frame(V, 24'h4080C0, 24'h4080C0, -1, 2'd0);
    chk("f3 pixlast", 32'(last_out[HV-1]), 32'h4080C0);

    // Mode 1 averaging
    frame(V, 24'h000000, 24'h000000, -1, 2'd0);
    frame(V, 24'hFFFFFF, 24'hFFFFFF, -1, 2'd0);
    chk("m1 up pix0",    32'(last_out[0]), 32'h808080);
    chk("m1 up pixlast", 32'(last_out[HV-1]), 32'h808080);
    frame(V, 24'hFFFFFF, 24'hFFFFFF, -1, 2'd0);
    chk("m1 steady pix0", 32'(last_out[0]), 32'hFFFFFF);

    // Mode 2 weighting: (3c+p+2)>>2
    blend_mode = 2'd2;
    frame(V, 24'h000000, 24'h000000, -1, 2'd0);
    chk("m2 down pix0",    32'(last_out[0]), 32'h404040);
    chk("m2 down pixH-1",  32'(last_out[H-1]), 32'h404040);
    chk("m2 down pixlast", 32'(last_out[HV-1]), 32'h404040);
    frame(V, 24'hFFFFFF, 24'hFFFFFF, -1, 2'd0);
    chk("m2 up pix0",    32'(last_out[0]), 32'hBFBFBF);
    chk("m2 up pixH-1",  32'(last_out[H-1]), 32'hBFBFBF);
    chk("m2 up pixlast", 32'(last_out[HV-1]), 32'hBFBFBF);

    // Short frame invalidates the following frame
    frame(V / 2, 24'h111111, 24'h111111, -1, 2'd0);
    frame(V, 24'h202020, 24'hE0E0E0, -1, 2'd0);
    chk("short fv", 32'(frame_valid), 32'h0);
    chk("short pix0", 32'(last_out[0]), 32'h202020);
    chk("short pix1", 32'(last_out[1]), 32'hE0E0E0);
    frame(V, 24'h000000, 24'h000000, -1, 2'd0);
    chk("resume fv", 32'(frame_valid), 32'h1);
    chk("resume pix0", 32'(last_out[0]), 32'h080808);
    chk("resume pix1", 32'(last_out[1]), 32'h383838);

    // Mode change mid-frame only takes effect at the next frame start
    blend_mode = 2'd1;
    frame(V, 24'hFFFFFF, 24'hFFFFFF, V / 2, 2'd0);
    chk("switch fv", 32'(frame_valid), 32'h1);
    chk("switch pixlast", 32'(last_out[HV-1]), 32'h808080);
    frame(V, 24'h000000, 24'h000000, -1, 2'd0);
    chk("bypass fv", 32'(frame_valid), 32'h0);
    chk("bypass pix0", 32'(last_out[0]), 32'h000000);

    // Random sync/blank traffic, bypass mode, sparse ce_pix
    gap = 10;
    for (int i = 0; i < 300; i++)
      pix(1'($urandom % 2), 1'(($urandom % 6) == 0), 1'($urandom % 2), 24'($urandom), -1);
    gap = 1;

    // Mid-frame reset drops frame_valid and returns to pass-through
    blend_mode = 2'd1;
    frame(V, 24'h102030, 24'h102030, -1, 2'd0);
    frame(V, 24'h102030, 24'h102030, -1, 2'd0);
    frame(V / 2, 24'h102030, 24'h102030, -1, 2'd0);
    for (int x = 0; x < 5; x++) pix(1'b0, 1'b0, 1'b0, 24'h102030, x);
    chk("pre-reset fv", 32'(frame_valid), 32'h1);
    do_reset();
    frame(V, 24'h505050, 24'hA0A0A0, -1, 2'd0);
    chk("post-reset fv", 32'(frame_valid), 32'h0);
    chk("post-reset pix0", 32'(last_out[0]), 32'h505050);
    chk("post-reset pix1", 32'(last_out[1]), 32'hA0A0A0);

    // Overlong frame clears frame_valid for the next frame
    frame(V + 1, 24'h222222, 24'h222222, -1, 2'd0);
    chk("overlong prior fv", 32'(frame_valid), 32'h1);
    frame(V, 24'h333333, 24'h333333, -1, 2'd0);
    chk("overlong fv", 32'(frame_valid), 32'h0);
    chk("overlong pix0", 32'(last_out[0]), 32'h333333);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
